// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types for the load/store unit: access-size encoding
//               (funct3) and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    // funct3 encodings of the supported memory access sizes
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_t;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam int unsigned LSU_XLEN = 32;

endpackage : load_store_unit_pkg

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Core-side request/response and data-memory bus signals of the
//               load/store unit. The master modport is the LSU itself (it
//               masters the memory bus); slave is the core + memory side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // core side
    logic                lsu_valid;
    logic                lsu_we;
    logic [2:0]          lsu_funct3;
    logic [LSU_XLEN-1:0] lsu_addr;
    logic [LSU_XLEN-1:0] lsu_wdata;
    logic                lsu_stall;
    logic                lsu_done;
    logic [LSU_XLEN-1:0] lsu_rdata;
    logic                lsu_misaligned;
    logic                lsu_bus_err;

    // data-memory bus
    logic                mem_req;
    logic                mem_we;
    logic [LSU_XLEN-1:0] mem_addr;
    logic [3:0]          mem_be;
    logic [LSU_XLEN-1:0] mem_wdata;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [LSU_XLEN-1:0] mem_rdata;

    modport master (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_stall, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_stall, lsu_done, lsu_rdata, lsu_misaligned, lsu_bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface : load_store_unit_if

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane logic: store byte enables and lane
//               replication, load extraction with sign/zero extension, and
//               misalignment / illegal-size detection from funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import load_store_unit_pkg::*;
(
    input  wire logic [2:0]  funct3_i,
    input  wire logic [1:0]  offset_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [31:0] rdata_i,
    output logic      [3:0]  be_o,
    output logic      [31:0] wdata_o,
    output logic      [31:0] rdata_o,
    output logic             misaligned_o,
    output logic             illegal_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selected by the address offset; halves only use offset bit 1
    assign w_byte = rdata_i[{offset_i, 3'b000} +: 8];
    assign w_half = rdata_i[{offset_i[1], 4'b0000} +: 16];

    // Size decode: steering, extension and alignment checks
    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = 32'h0;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            LSU_B, LSU_BU: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            LSU_H, LSU_HU: begin
                be_o         = 4'b0011 << offset_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = funct3_i[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                misaligned_o = offset_i[0];
            end
            LSU_W: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                rdata_o      = rdata_i;
                misaligned_o = |offset_i;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : lsu_align

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Sequences one load/store per valid
//               instruction over a valid/grant/response bus, stalls the core
//               until completion, and reports misalignment / bus errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    load_store_unit_if.master  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;

    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;
    logic        w_mis;
    logic        w_al_illegal;
    logic        w_illegal;
    logic        w_timeout;
    logic        w_req;
    logic        w_done;

    // The aligner decodes the live request in IDLE and the latched one after
    assign w_f3  = (state_q == S_IDLE) ? bus.lsu_funct3    : f3_q;
    assign w_off = (state_q == S_IDLE) ? bus.lsu_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i     (w_f3),
        .offset_i     (w_off),
        .wdata_i      (bus.lsu_wdata),
        .rdata_i      (bus.mem_rdata),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .rdata_o      (w_ext),
        .misaligned_o (w_mis),
        .illegal_o    (w_al_illegal)
    );

    // Unsigned sizes have no store form
    assign w_illegal = w_al_illegal | (bus.lsu_we & bus.lsu_funct3[2]);
    assign w_timeout = (cnt_q == C_CNT_LAST);

    // Next-state logic: access sequencing, timeout and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.lsu_valid) begin
                    if (w_mis) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (w_illegal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = bus.lsu_addr[31:2];
                        we_d    = bus.lsu_we;
                        f3_d    = bus.lsu_funct3;
                        off_d   = bus.lsu_addr[1:0];
                        be_d    = bus.lsu_we ? w_be : 4'b1111;
                        wdata_d = bus.lsu_we ? w_wdata : 32'h0;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d = w_ext;
                    state_d = S_DONE;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                // Result is presented for this one cycle; clear it for the next access
                rdata_d = 32'h0;
                mis_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign w_req  = (state_q == S_REQ);
    assign w_done = (state_q == S_DONE);

    // Bus fields are only driven while requesting so idle outputs read zero
    assign bus.mem_req        = w_req;
    assign bus.mem_we         = w_req & we_q;
    assign bus.mem_addr       = w_req ? {addr_q, 2'b00} : 32'h0;
    assign bus.mem_be         = w_req ? be_q : 4'b0000;
    assign bus.mem_wdata      = w_req ? wdata_q : 32'h0;

    assign bus.lsu_done       = w_done;
    assign bus.lsu_rdata      = w_done ? rdata_q : 32'h0;
    assign bus.lsu_misaligned = w_done & mis_q;
    assign bus.lsu_bus_err    = w_done & err_q;
    assign bus.lsu_stall      = bus.lsu_valid & ~w_done;

endmodule : load_store_unit

`default_nettype wire
